w_mem_stream_reader: RTL and testbench

//  Read-side sequencer for a per-neuron weight ROM: 1-cycle registered read, ren/radd in, wout out.
//  On start, fetches weights 0..numWeight-1 in order and streams them to the neuron MAC

---
 rtl/w_mem_stream_reader.sv | 150 +++++++++++++++
 tb/tb_w_mem_stream_reader.sv | 471 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/w_mem_stream_reader.sv
// Weight ROM read sequencer.
// Streams one neuron's weight set to the MAC over valid/ready.
module w_mem_stream_reader #(
  parameter int numWeight    = 30,
  parameter int addressWidth =
    (numWeight > 1) ? $clog2(numWeight) : 1,
  parameter int dataWidth    = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    mem_ren,
  output logic [addressWidth-1:0] mem_radd,
  input  logic [dataWidth-1:0]    mem_wout,
  output logic                    w_valid,
  input  logic                    w_ready,
  output logic [dataWidth-1:0]    w_data,
  output logic [addressWidth-1:0] w_idx,
  output logic                    w_last,
  output logic                    busy,
  output logic                    done
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 3);

  localparam logic [addressWidth-1:0] LAST_IDX =
    addressWidth'(numWeight - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]              state;
  logic [addressWidth-1:0] nxt_addr;

  logic                    rd_pend;
  logic [addressWidth-1:0] rd_idx;

  logic [dataWidth-1:0]    f_data [FIFO_DEPTH];
  logic [addressWidth-1:0] f_idx  [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic [CW-1:0]           count;

  logic f_empty;
  logic hs;
  logic push;
  logic pop;
  logic credit_ok;

  assign f_empty = (count == '0);
  assign busy    = (state != IDLE);

  // Present the FIFO head, or the returning ROM word when the FIFO is empty.
  always_comb begin
    w_valid = 1'b0;
    w_data  = '0;
    w_idx   = '0;
    if (!f_empty) begin
      w_valid = 1'b1;
      w_data  = f_data[rd_ptr];
      w_idx   = f_idx[rd_ptr];
    end else if (rd_pend) begin
      w_valid = 1'b1;
      w_data  = mem_wout;
      w_idx   = rd_idx;
    end
    w_last = w_valid && (w_idx == LAST_IDX);
  end

  assign hs   = w_valid && w_ready;
  assign pop  = hs && !f_empty;
  assign push = rd_pend && !(f_empty && w_ready);

  // Reads in flight count against FIFO space so a return always fits.
  assign credit_ok =
    (count + CW'(mem_ren) + CW'(rd_pend)) < CW'(FIFO_DEPTH);

  // Sequencer: issue reads, track completion of the last beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      mem_ren  <= 1'b0;
      mem_radd <= '0;
      nxt_addr <= '0;
      rd_pend  <= 1'b0;
      rd_idx   <= '0;
      done     <= 1'b0;
    end else begin
      done    <= 1'b0;
      mem_ren <= 1'b0;
      rd_pend <= mem_ren;
      if (mem_ren) rd_idx <= mem_radd;
      case (state)
        IDLE: begin
          if (start) begin
            mem_ren  <= 1'b1;
            mem_radd <= '0;
            nxt_addr <= addressWidth'(1);
            state    <= (numWeight == 1) ? DRAIN : FETCH;
          end
        end
        FETCH: begin
          if (credit_ok) begin
            mem_ren  <= 1'b1;
            mem_radd <= nxt_addr;
            nxt_addr <= nxt_addr + addressWidth'(1);
            if (nxt_addr == LAST_IDX) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (hs && w_last) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO occupancy and pointers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      assert (!(push && !pop && count == CW'(FIFO_DEPTH)));
      if (push)
        wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ?
                  '0 : wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ?
                  '0 : rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clk) begin
    if (push) begin
      f_data[wr_ptr] <= mem_wout;
      f_idx[wr_ptr]  <= rd_idx;
    end
  end

endmodule

// File: tb/tb_w_mem_stream_reader.sv
// Bench for w_mem_stream_reader.
// Random ROM/ready against an in-order stream model.
module tb_w_mem_stream_reader;

  localparam int NW    = 30;
  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        mem_ren;
  logic [4:0]  mem_radd;
  logic [15:0] mem_wout;
  logic        w_valid;
  logic        w_ready;
  logic [15:0] w_data;
  logic [4:0]  w_idx;
  logic        w_last;
  logic        busy;
  logic        done;

  logic        start1;
  logic        mem_ren1;
  logic [0:0]  mem_radd1;
  logic [15:0] mem_wout1;
  logic        w_valid1;
  logic        ready1;
  logic [15:0] w_data1;
  logic [0:0]  w_idx1;
  logic        w_last1;
  logic        busy1;
  logic        done1;

  logic [15:0] rom [NW];
  logic [15:0] rom1;

  int checks;
  int errors;
  int iss;
  int acc;

  w_mem_stream_reader #(
    .numWeight(NW), .dataWidth(16), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .mem_ren(mem_ren), .mem_radd(mem_radd), .mem_wout(mem_wout),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .w_idx(w_idx), .w_last(w_last), .busy(busy), .done(done)
  );

  w_mem_stream_reader #(
    .numWeight(1), .dataWidth(16), .FIFO_DEPTH(DEPTH)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .mem_ren(mem_ren1), .mem_radd(mem_radd1), .mem_wout(mem_wout1),
    .w_valid(w_valid1), .w_ready(ready1), .w_data(w_data1),
    .w_idx(w_idx1), .w_last(w_last1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  // ROM models: registered read, output holds when not enabled.
  always @(posedge clk) begin
    if (mem_ren) mem_wout <= rom[mem_radd];
    if (mem_ren1) mem_wout1 <= rom1;
  end

  // Reads issued and beats accepted since reset.
  always @(posedge clk) begin
    if (!rst_n) begin
      iss = 0;
      acc = 0;
    end else begin
      if (mem_ren) iss = iss + 1;
      if (w_valid && w_ready) acc = acc + 1;
    end
  end

  task automatic test_reset();
    rst_n = 0; start = 0; w_ready = 0;
    start1 = 0; ready1 = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_ren, mem_radd, w_valid, w_data, w_idx,
         w_last, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset: got ren=%b radd=%0d v=%b d=%h i=%0d l=%b b=%b dn=%b, need all 0",
               mem_ren, mem_radd, w_valid, w_data, w_idx,
               w_last, busy, done);
    end
    checks++;
    if ({mem_ren1, w_valid1, busy1, done1} !== 4'b0) begin
      errors++;
      $display("FAIL reset_nw1: got %b, need 0000",
               {mem_ren1, w_valid1, busy1, done1});
    end
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_full_speed();
    @(negedge clk);
    start = 1; w_ready = 1;
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      start = 0;
      if (c == 1) begin
        checks++;
        if (mem_ren !== 1'b1 || mem_radd !== 5'd0) begin
          errors++;
          $display("FAIL full_first_read: ren=%b radd=%0d, need 1/0",
                   mem_ren, mem_radd);
        end
      end
      checks++;
      if (busy !== (c <= 31)) begin
        errors++;
        $display("FAIL full_busy c%0d: got %b need %b",
                 c, busy, (c <= 31));
      end
      checks++;
      if (done !== (c == 32)) begin
        errors++;
        $display("FAIL full_done c%0d: got %b need %b",
                 c, done, (c == 32));
      end
      checks++;
      if (c >= 2 && c <= 31) begin
        if (w_valid !== 1'b1 || w_idx !== 5'(c - 2) ||
            w_data !== rom[c-2] || w_last !== (c == 31)) begin
          errors++;
          $display("FAIL full_beat c%0d: v=%b i=%0d d=%h l=%b, need 1/%0d/%h/%b",
                   c, w_valid, w_idx, w_data, w_last,
                   c - 2, rom[c-2], (c == 31));
        end
      end else if (w_valid !== 1'b0) begin
        errors++;
        $display("FAIL full_idle c%0d: w_valid=%b need 0",
                 c, w_valid);
      end
    end
    w_ready = 0;
  endtask

  task automatic test_backpressure();
    int  exp;
    int  stall;
    bit  used;
    bit  fin;
    exp = 0; stall = 0; used = 0; fin = 0;
    @(negedge clk);
    start = 1; w_ready = 1;
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      @(negedge clk);
      start = 0;
      checks++;
      if (iss + int'(mem_ren) - acc > DEPTH) begin
        errors++;
        $display("FAIL bp_credit: outstanding=%0d, need <=%0d",
                 iss + int'(mem_ren) - acc, DEPTH);
      end
      if (done) begin
        fin = 1;
        checks++;
        if (exp != NW) begin
          errors++;
          $display("FAIL bp_count: beats=%0d need %0d", exp, NW);
        end
      end
      if (w_valid) begin
        checks++;
        if (w_idx !== 5'(exp) || w_data !== rom[exp] ||
            w_last !== (exp == NW - 1)) begin
          errors++;
          $display("FAIL bp_beat: i=%0d d=%h l=%b, need %0d/%h/%b",
                   w_idx, w_data, w_last, exp, rom[exp],
                   (exp == NW - 1));
        end
        if (w_idx == 5'd5 && !used) begin
          used = 1;
          stall = 10;
        end
      end
      if (stall > 0) begin
        w_ready = 0;
        if (stall == 1) begin
          checks++;
          if (mem_ren !== 1'b0 || iss - acc != DEPTH) begin
            errors++;
            $display("FAIL bp_throttle: ren=%b outstanding=%0d, need 0/%0d",
                     mem_ren, iss - acc, DEPTH);
          end
        end
        stall--;
      end else begin
        w_ready = 1;
      end
      if (w_valid && w_ready) exp++;
    end
    if (!fin) begin
      errors++;
      $display("FAIL bp_timeout: beats=%0d, no done", exp);
    end
    w_ready = 0;
  endtask

  task automatic test_random();
    int exp;
    int dones;
    exp = 0; dones = 0;
    @(negedge clk);
    start = 1;
    w_ready = 1'($urandom_range(0, 1));
    for (int cyc = 0; cyc < 3000 && dones < 3; cyc++) begin
      @(negedge clk);
      start = 0;
      checks++;
      if (iss + int'(mem_ren) - acc > DEPTH) begin
        errors++;
        $display("FAIL rnd_credit: outstanding=%0d, need <=%0d",
                 iss + int'(mem_ren) - acc, DEPTH);
      end
      if (done) begin
        dones++;
        checks++;
        if (exp != NW) begin
          errors++;
          $display("FAIL rnd_count s%0d: beats=%0d need %0d",
                   dones, exp, NW);
        end
        exp = 0;
        if (dones < 3) start = 1;
      end
      if (w_valid) begin
        checks++;
        if (exp >= NW || w_idx !== 5'(exp) ||
            w_data !== rom[exp] ||
            w_last !== (exp == NW - 1)) begin
          errors++;
          $display("FAIL rnd_beat: i=%0d d=%h l=%b, need idx %0d",
                   w_idx, w_data, w_last, exp);
        end
      end
      w_ready = 1'($urandom_range(0, 1));
      if (w_valid && w_ready) exp++;
    end
    checks++;
    if (dones != 3) begin
      errors++;
      $display("FAIL rnd_streams: dones=%0d need 3", dones);
    end
    w_ready = 1;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || w_valid !== 1'b0) begin
        errors++;
        $display("FAIL rnd_after: done=%b valid=%b need 0/0",
                 done, w_valid);
      end
    end
    w_ready = 0;
  endtask

  task automatic test_start_busy();
    int exp;
    bit fin;
    exp = 0; fin = 0;
    @(negedge clk);
    start = 1; w_ready = 1;
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      @(negedge clk);
      start = 0;
      if (done) begin
        fin = 1;
        checks++;
        if (exp != NW) begin
          errors++;
          $display("FAIL sb_count: beats=%0d need %0d", exp, NW);
        end
        start = 1;
      end
      if (w_valid) begin
        checks++;
        if (w_idx !== 5'(exp) || w_data !== rom[exp]) begin
          errors++;
          $display("FAIL sb_beat: i=%0d d=%h, need %0d/%h",
                   w_idx, w_data, exp, rom[exp]);
        end
        if (w_idx == 5'd10) start = 1;
        exp++;
      end
    end
    if (!fin) begin
      errors++;
      $display("FAIL sb_timeout: beats=%0d, no done", exp);
    end
    @(negedge clk);
    start = 0;
    checks++;
    if (mem_ren !== 1'b1 || mem_radd !== 5'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL sb_done_start: ren=%b radd=%0d busy=%b, need 1/0/1",
               mem_ren, mem_radd, busy);
    end
    exp = 0; fin = 0;
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      @(negedge clk);
      if (done) begin
        fin = 1;
        checks++;
        if (exp != NW) begin
          errors++;
          $display("FAIL sb_count2: beats=%0d need %0d", exp, NW);
        end
      end
      if (w_valid) begin
        checks++;
        if (w_idx !== 5'(exp) || w_data !== rom[exp]) begin
          errors++;
          $display("FAIL sb_beat2: i=%0d d=%h, need %0d/%h",
                   w_idx, w_data, exp, rom[exp]);
        end
        exp++;
      end
    end
    if (!fin) begin
      errors++;
      $display("FAIL sb_timeout2: beats=%0d, no done", exp);
    end
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || w_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL sb_idle: done=%b valid=%b busy=%b need 0",
                 done, w_valid, busy);
      end
    end
    w_ready = 0;
  endtask

  task automatic test_reset_mid();
    int exp;
    bit hit;
    bit fin;
    hit = 0;
    @(negedge clk);
    start = 1; w_ready = 1;
    for (int cyc = 0; cyc < 100 && !hit; cyc++) begin
      @(negedge clk);
      start = 0;
      if (w_valid && w_idx == 5'd12) begin
        hit = 1;
        rst_n = 0;
      end
    end
    if (!hit) begin
      errors++;
      $display("FAIL rm_timeout: beat 12 never presented");
      rst_n = 0;
    end
    @(negedge clk);
    checks++;
    if ({mem_ren, mem_radd, w_valid, w_data, w_idx,
         w_last, busy, done} !== '0) begin
      errors++;
      $display("FAIL rm_reset: ren=%b radd=%0d v=%b d=%h i=%0d, need all 0",
               mem_ren, mem_radd, w_valid, w_data, w_idx);
    end
    rst_n = 1;
    repeat (6) begin
      @(negedge clk);
      checks++;
      if (w_valid !== 1'b0 || mem_ren !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rm_stale: valid=%b ren=%b busy=%b need 0",
                 w_valid, mem_ren, busy);
      end
    end
    exp = 0; fin = 0;
    start = 1;
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      @(negedge clk);
      start = 0;
      if (done) begin
        fin = 1;
        checks++;
        if (exp != NW) begin
          errors++;
          $display("FAIL rm_count: beats=%0d need %0d", exp, NW);
        end
      end
      if (w_valid) begin
        checks++;
        if (w_idx !== 5'(exp) || w_data !== rom[exp]) begin
          errors++;
          $display("FAIL rm_beat: i=%0d d=%h, need %0d/%h",
                   w_idx, w_data, exp, rom[exp]);
        end
        exp++;
      end
    end
    if (!fin) begin
      errors++;
      $display("FAIL rm_timeout2: beats=%0d, no done", exp);
    end
    w_ready = 0;
  endtask

  task automatic test_nw1();
    int bc;
    bc = 0;
    @(negedge clk);
    start1 = 1; ready1 = 1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start1 = 0;
      if (busy1) bc++;
      checks++;
      if (c == 2) begin
        if (w_valid1 !== 1'b1 || w_idx1 !== 1'b0 ||
            w_last1 !== 1'b1 || w_data1 !== rom1) begin
          errors++;
          $display("FAIL nw1_beat: v=%b i=%0d l=%b d=%h, need 1/0/1/%h",
                   w_valid1, w_idx1, w_last1, w_data1, rom1);
        end
      end else if (w_valid1 !== 1'b0) begin
        errors++;
        $display("FAIL nw1_idle c%0d: valid=%b need 0", c, w_valid1);
      end
      checks++;
      if (done1 !== (c == 3)) begin
        errors++;
        $display("FAIL nw1_done c%0d: got %b need %b",
                 c, done1, (c == 3));
      end
    end
    checks++;
    if (bc != 2) begin
      errors++;
      $display("FAIL nw1_busy: busy cycles=%0d need 2", bc);
    end
    ready1 = 0;
  endtask

  initial begin
    clk = 0;
    checks = 0;
    errors = 0;
    iss = 0;
    acc = 0;
    mem_wout = '0;
    mem_wout1 = '0;
    for (int i = 0; i < NW; i++) rom[i] = 16'($urandom);
    rom[0]  = 16'hF44B;
    rom[29] = 16'h0169;
    rom1    = 16'($urandom) | 16'h8000;
    test_reset();
    test_full_speed();
    test_backpressure();
    test_random();
    test_start_busy();
    test_reset_mid();
    test_nw1();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
